// File: rtl/dmem_rv32_if.sv
// ---------------------------------------------------------------------------
// dmem_rv32_if
//
// Bus bundle between the load/store stage (master) and the RV32 data memory
// (slave). There is no handshake: every access completes in one cycle.
//
// Signals:
//   addr     32  byte address
//   w_data   32  store data (low byte / low half / full word used per ctrl)
//   ctrl      3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   w_en      1  store enable
//   outdata  32  combinational load data
//   err       1  sticky misalignment flag (registered)
// ---------------------------------------------------------------------------
interface dmem_rv32_if;
  logic [31:0] addr;
  logic [31:0] w_data;
  logic [2:0]  ctrl;
  logic        w_en;
  logic [31:0] outdata;
  logic        err;

  modport master (
    output addr,
    output w_data,
    output ctrl,
    output w_en,
    input  outdata,
    input  err
  );

  modport slave (
    input  addr,
    input  w_data,
    input  ctrl,
    input  w_en,
    output outdata,
    output err
  );
endinterface

// File: rtl/dmem_rv32.sv
// ---------------------------------------------------------------------------
// dmem_rv32
//
// RV32 data memory: byte-addressed, little-endian, word-organised storage of
// 2^ADDR_WIDTH 32-bit words. Stores commit on the rising CLK edge, loads are
// combinational. ctrl (funct3) selects access size and load extension.
// Address bits above ADDR_WIDTH+1 are ignored, so addresses wrap.
//
// Ports:
//   CLK   clock, all state changes on the rising edge
//   RST   synchronous active-high reset; clears every word and err
//   bus   dmem_rv32_if.slave (addr, w_data, ctrl, w_en, outdata, err)
//
// Optional feature, macro DMEM_MISALIGN_CHECK_EN:
//   defined   - misaligned half/word accesses are detected: the store is
//               suppressed, the load returns 0 and err is set (sticky
//               until RST).
//   undefined - no checking, err tied to 0; half accesses ignore addr[0]
//               and word accesses ignore addr[1:0].
// ---------------------------------------------------------------------------
module dmem_rv32 #(
  parameter int ADDR_WIDTH = 8
) (
  input logic        CLK,
  input logic        RST,
  dmem_rv32_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]            lane;
  logic                  misaligned;

  logic [3:0]  wr_be;
  logic [31:0] wr_word;

  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Upper address bits are deliberately discarded (address wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.addr[31:ADDR_WIDTH+2];

  assign word_idx = bus.addr[ADDR_WIDTH+1:2];
  assign lane     = bus.addr[1:0];

`ifdef DMEM_MISALIGN_CHECK_EN
  logic half_acc;
  logic word_acc;
  logic err_q;

  // Half covers both H and HU; word is only W. Bytes can never be misaligned.
  assign half_acc   = (bus.ctrl[1:0] == 2'b01);
  assign word_acc   = (bus.ctrl == 3'b010);
  assign misaligned = (half_acc & bus.addr[0]) | (word_acc & (bus.addr[1:0] != 2'b00));

  // Sticky flag: any misaligned access, store or load, sets it on the next edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      err_q <= 1'b0;
    end else if (misaligned) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign misaligned = 1'b0;
  assign bus.err    = 1'b0;
`endif

  // Byte-enable mask and lane-replicated store data. The data is replicated
  // across lanes so the mask alone decides which bytes land.
  always_comb begin
    wr_be   = 4'b0000;
    wr_word = 32'h0;
    case (bus.ctrl)
      3'b000: begin
        wr_be   = 4'b0001 << lane;
        wr_word = {4{bus.w_data[7:0]}};
      end
      3'b001: begin
        wr_be   = bus.addr[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{bus.w_data[15:0]}};
      end
      3'b010: begin
        wr_be   = 4'b1111;
        wr_word = bus.w_data;
      end
      default: begin
        wr_be   = 4'b0000;
        wr_word = 32'h0;
      end
    endcase
    if (!bus.w_en || misaligned) begin
      wr_be = 4'b0000;
    end
  end

  // Storage: reset wins over any store; otherwise only enabled bytes change.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'h0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
        end
      end
    end
  end

  // Combinational load path: select lane/half, then extend per funct3.
  always_comb begin
    rd_word = mem[word_idx];
    case (lane)
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = bus.addr[1] ? rd_word[31:16] : rd_word[15:0];

    bus.outdata = 32'h0;
    case (bus.ctrl)
      3'b000:  bus.outdata = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  bus.outdata = {{16{rd_half[15]}}, rd_half};
      3'b010:  bus.outdata = rd_word;
      3'b100:  bus.outdata = {24'h0, rd_byte};
      3'b101:  bus.outdata = {16'h0, rd_half};
      default: bus.outdata = 32'h0;
    endcase
    if (misaligned) begin
      bus.outdata = 32'h0;
    end
  end

endmodule

// File: tb/tb_dmem_rv32.sv
// ---------------------------------------------------------------------------
// tb_dmem_rv32
//
// Self-checking bench for dmem_rv32 (default ADDR_WIDTH = 8, 1 KiB).
// The reference model is a plain 1 KiB byte array plus a sticky error bit;
// loads and stores are computed byte by byte from byte addresses.
// Build with DMEM_MISALIGN_CHECK_EN defined to exercise the checked variant.
// ---------------------------------------------------------------------------
module tb_dmem_rv32;

  logic CLK;
  logic RST;

  dmem_rv32_if bus ();

  dmem_rv32 #(.ADDR_WIDTH(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_compared;
  int n_mismatched;

  logic [7:0] model_mem [1024];
  logic       model_err;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic bit model_misaligned(input logic [31:0] a, input logic [2:0] c);
`ifdef DMEM_MISALIGN_CHECK_EN
    if ((c == 3'b001 || c == 3'b101) && a[0]) return 1'b1;
    if (c == 3'b010 && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] c);
    int          ba;
    int          hb;
    int          wb;
    logic [7:0]  b;
    logic [15:0] h;
    ba = int'(a % 1024);
    hb = ba - (ba % 2);
    wb = ba - (ba % 4);
    b  = model_mem[ba];
    h  = {model_mem[hb + 1], model_mem[hb]};
    if (model_misaligned(a, c)) return 32'h0;
    case (c)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return {model_mem[wb + 3], model_mem[wb + 2], model_mem[wb + 1], model_mem[wb]};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] d,
                             input logic [2:0] c, input logic en);
    int ba;
    int hb;
    int wb;
    ba = int'(a % 1024);
    hb = ba - (ba % 2);
    wb = ba - (ba % 4);
    if (model_misaligned(a, c)) model_err = 1'b1;
    if (!en || model_misaligned(a, c)) return;
    case (c)
      3'b000: model_mem[ba] = d[7:0];
      3'b001: begin
        model_mem[hb]     = d[7:0];
        model_mem[hb + 1] = d[15:8];
      end
      3'b010: begin
        for (int k = 0; k < 4; k++) model_mem[wb + k] = d[8*k +: 8];
      end
      default: ;
    endcase
  endtask

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic apply_reset();
    @(negedge CLK);
    RST        = 1'b1;
    bus.w_en   = 1'b0;
    @(posedge CLK);
    for (int i = 0; i < 1024; i++) model_mem[i] = 8'h00;
    model_err = 1'b0;
    #1;
    RST = 1'b0;
  endtask

  task automatic set_load(input logic [31:0] a, input logic [2:0] c);
    @(negedge CLK);
    bus.addr   = a;
    bus.ctrl   = c;
    bus.w_en   = 1'b0;
    bus.w_data = 32'h0;
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
    @(negedge CLK);
    bus.addr   = a;
    bus.w_data = d;
    bus.ctrl   = c;
    bus.w_en   = 1'b1;
    @(posedge CLK);
    model_store(a, d, c, 1'b1);
    #1;
    bus.w_en = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] addrs [2];
    addrs = '{32'h0, 32'h3FC};
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      set_load(addrs[i], 3'b010);
      n_compared++;
      if (bus.outdata !== 32'h0) begin
        n_mismatched++;
        $display("[TB] FAIL reset_lw addr=%h got %h expected %h", addrs[i], bus.outdata, 32'h0);
      end
      n_compared++;
      if (bus.err !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL reset_err got %b expected 0", bus.err);
      end
    end
  endtask

  task automatic test_word_half_byte();
    logic [2:0]  cs  [5];
    logic [31:0] ex1 [5];
    logic [31:0] ex2 [5];
    cs  = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    ex1 = '{32'h00000078, 32'h00005678, 32'h12345678, 32'h00000078, 32'h00005678};
    ex2 = '{32'hfffffff8, 32'hfffff6f8, 32'h1234f6f8, 32'h000000f8, 32'h0000f6f8};
    do_store(32'h0, 32'h12345678, 3'b010);
    for (int i = 0; i < 5; i++) begin
      set_load(32'h0, cs[i]);
      n_compared++;
      if (bus.outdata !== ex1[i]) begin
        n_mismatched++;
        $display("[TB] FAIL sw_load ctrl=%0d got %h expected %h", cs[i], bus.outdata, ex1[i]);
      end
    end
    do_store(32'h0, 32'hf123f6f8, 3'b001);
    for (int i = 0; i < 5; i++) begin
      set_load(32'h0, cs[i]);
      n_compared++;
      if (bus.outdata !== ex2[i]) begin
        n_mismatched++;
        $display("[TB] FAIL sh_load ctrl=%0d got %h expected %h", cs[i], bus.outdata, ex2[i]);
      end
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] la [3];
    logic [2:0]  lc [3];
    logic [31:0] le [3];
    la = '{32'h4, 32'h6, 32'h7};
    lc = '{3'b010, 3'b000, 3'b100};
    le = '{32'h00AA0000, 32'hffffffaa, 32'h00000000};
    do_store(32'h6, 32'h000000AA, 3'b000);
    for (int i = 0; i < 3; i++) begin
      set_load(la[i], lc[i]);
      n_compared++;
      if (bus.outdata !== le[i]) begin
        n_mismatched++;
        $display("[TB] FAIL sb_lane addr=%h got %h expected %h", la[i], bus.outdata, le[i]);
      end
    end
  endtask

  task automatic test_wrap();
    do_store(32'h400, 32'hDEADBEEF, 3'b010);
    set_load(32'h0, 3'b010);
    n_compared++;
    if (bus.outdata !== 32'hDEADBEEF) begin
      n_mismatched++;
      $display("[TB] FAIL wrap got %h expected %h", bus.outdata, 32'hDEADBEEF);
    end
  endtask

  task automatic test_read_during_write();
    do_store(32'h10, 32'h0BADF00D, 3'b010);
    @(negedge CLK);
    bus.addr   = 32'h10;
    bus.w_data = 32'hCAFE1234;
    bus.ctrl   = 3'b010;
    bus.w_en   = 1'b1;
    #1;
    n_compared++;
    if (bus.outdata !== 32'h0BADF00D) begin
      n_mismatched++;
      $display("[TB] FAIL rdw_before got %h expected %h", bus.outdata, 32'h0BADF00D);
    end
    @(posedge CLK);
    model_store(32'h10, 32'hCAFE1234, 3'b010, 1'b1);
    #1;
    n_compared++;
    if (bus.outdata !== 32'hCAFE1234) begin
      n_mismatched++;
      $display("[TB] FAIL rdw_after got %h expected %h", bus.outdata, 32'hCAFE1234);
    end
    bus.w_en = 1'b0;
  endtask

  task automatic test_misalign();
    apply_reset();
    do_store(32'h0, 32'h55667788, 3'b010);
`ifdef DMEM_MISALIGN_CHECK_EN
    // Misaligned SW: load returns 0 before the edge, store suppressed, err set.
    @(negedge CLK);
    bus.addr   = 32'h2;
    bus.w_data = 32'h11111111;
    bus.ctrl   = 3'b010;
    bus.w_en   = 1'b1;
    #1;
    n_compared++;
    if (bus.outdata !== 32'h0 || bus.err !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL mis_before outdata=%h err=%b expected 00000000 0", bus.outdata, bus.err);
    end
    @(posedge CLK);
    model_store(32'h2, 32'h11111111, 3'b010, 1'b1);
    #1;
    bus.w_en = 1'b0;
    n_compared++;
    if (bus.err !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL mis_err_set got %b expected 1", bus.err);
    end
    set_load(32'h0, 3'b010);
    n_compared++;
    if (bus.outdata !== 32'h55667788) begin
      n_mismatched++;
      $display("[TB] FAIL mis_suppressed got %h expected %h", bus.outdata, 32'h55667788);
    end
    do_store(32'h8, 32'h01020304, 3'b010);
    set_load(32'h8, 3'b010);
    n_compared++;
    if (bus.err !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL mis_sticky got %b expected 1", bus.err);
    end
    apply_reset();
    set_load(32'h0, 3'b010);
    n_compared++;
    if (bus.err !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL mis_err_clear got %b expected 0", bus.err);
    end
    // Misaligned load (w_en=0) sets err on the following edge.
    set_load(32'h3, 3'b001);
    @(posedge CLK);
    #1;
    n_compared++;
    if (bus.err !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL mis_load_err got %b expected 1", bus.err);
    end
    apply_reset();
`else
    // Unchecked build: offsets inside a half/word are ignored, err stays 0.
    set_load(32'h1, 3'b101);
    n_compared++;
    if (bus.outdata !== 32'h00007788) begin
      n_mismatched++;
      $display("[TB] FAIL nochk_lhu got %h expected %h", bus.outdata, 32'h00007788);
    end
    set_load(32'h3, 3'b010);
    n_compared++;
    if (bus.outdata !== 32'h55667788) begin
      n_mismatched++;
      $display("[TB] FAIL nochk_lw got %h expected %h", bus.outdata, 32'h55667788);
    end
    do_store(32'h5, 32'h0000BEEF, 3'b001);
    set_load(32'h4, 3'b010);
    n_compared++;
    if (bus.outdata !== 32'h0000BEEF) begin
      n_mismatched++;
      $display("[TB] FAIL nochk_sh got %h expected %h", bus.outdata, 32'h0000BEEF);
    end
    n_compared++;
    if (bus.err !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL nochk_err got %b expected 0", bus.err);
    end
`endif
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  c;
    logic        en;
    logic [31:0] exp_v;
    for (int it = 0; it < 400; it++) begin
      a  = $urandom_range(0, 32'h7FF);
      if ($urandom_range(0, 3) == 0) a = a | 32'hFFFF_F000;
      d  = $urandom;
      c  = 3'($urandom_range(0, 7));
      en = 1'($urandom_range(0, 1));
      @(negedge CLK);
      bus.addr   = a;
      bus.w_data = d;
      bus.ctrl   = c;
      bus.w_en   = en;
      #1;
      exp_v = model_load(a, c);
      n_compared++;
      if (bus.outdata !== exp_v) begin
        n_mismatched++;
        $display("[TB] FAIL rand_pre it=%0d addr=%h ctrl=%0d got %h expected %h", it, a, c, bus.outdata, exp_v);
      end
      @(posedge CLK);
      model_store(a, d, c, en);
      #1;
      exp_v = model_load(a, c);
      n_compared++;
      if (bus.outdata !== exp_v || bus.err !== model_err) begin
        n_mismatched++;
        $display("[TB] FAIL rand_post it=%0d addr=%h ctrl=%0d got %h/%b expected %h/%b",
                 it, a, c, bus.outdata, bus.err, exp_v, model_err);
      end
      bus.w_en = 1'b0;
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    model_err    = 1'b0;
    RST          = 1'b1;
    bus.addr     = 32'h0;
    bus.w_data   = 32'h0;
    bus.ctrl     = 3'b010;
    bus.w_en     = 1'b0;

    test_reset();
    test_word_half_byte();
    test_byte_lanes();
    test_wrap();
    test_read_during_write();
    test_misalign();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
